// File: rtl/pattern_010_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_010_tx
// Purpose  : Frames a payload byte onto a serial line that feeds a 010
//            pattern detector. Frame layout, one cycle per symbol:
//              PRE0(0) PRE1(1) PRE2(0) DATA x8 (MSB first) [PAR] STOP(1)
//            The line idles high. Frames can run back-to-back, because a
//            byte may be accepted in the STOP cycle.
// Ports    : clk         - clock, rising edge
//            rst         - synchronous active-high reset
//            data_in     - payload byte
//            valid_in    - data_in holds a byte to send
//            ready_out   - a byte is accepted this cycle (IDLE or STOP)
//            x           - registered serial line, idles high
//            busy        - a frame is in progress (state != IDLE)
//            frame_count - completed frames, saturates at 1023
// Config   : define PATTERN_010_TX_PARITY_EN to add an even-parity bit
//            (PAR state). This makes a 13-cycle frame instead of 12.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_010_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       x,
    output logic       busy,
    output logic [9:0] frame_count
);

    localparam logic [9:0] c_FC_MAX  = 10'd1023;
    localparam logic [2:0] c_BIT_LAST = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE0 = 3'd1,
        S_PRE1 = 3'd2,
        S_PRE2 = 3'd3,
        S_DATA = 3'd4,
`ifdef PATTERN_010_TX_PARITY_EN
        S_PAR  = 3'd5,
`endif
        S_STOP = 3'd6
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       x_q, x_d;
    logic [9:0] fc_q, fc_d;
`ifdef PATTERN_010_TX_PARITY_EN
    logic       parity_q, parity_d;
`endif

    logic w_accept;

    assign ready_out   = (state_q == S_IDLE) || (state_q == S_STOP);
    assign w_accept    = valid_in && ready_out;
    assign x           = x_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_count = fc_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef PATTERN_010_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            S_IDLE, S_STOP: begin
                if (w_accept) begin
                    state_d   = S_PRE0;
                    shift_d   = data_in;
                    bit_cnt_d = 3'd0;
`ifdef PATTERN_010_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE0: state_d = S_PRE1;
            S_PRE1: state_d = S_PRE2;
            S_PRE2: state_d = S_DATA;
            S_DATA: begin
                if (bit_cnt_q == c_BIT_LAST) begin
                    bit_cnt_d = 3'd0;
`ifdef PATTERN_010_TX_PARITY_EN
                    state_d   = S_PAR;
`else
                    state_d   = S_STOP;
`endif
                end else begin
                    // Shift only while another data bit follows, so that
                    // shift_d[7] is always the bit for the next DATA cycle.
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = {shift_q[6:0], 1'b0};
                end
            end
`ifdef PATTERN_010_TX_PARITY_EN
            S_PAR: state_d = S_STOP;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // The line level is decoded from the next state. This makes x a plain
    // flop that always matches the state currently held, with no input path.
    always_comb begin
        x_d = 1'b1;
        case (state_d)
            S_IDLE: x_d = 1'b1;
            S_PRE0: x_d = 1'b0;
            S_PRE1: x_d = 1'b1;
            S_PRE2: x_d = 1'b0;
            S_DATA: x_d = shift_d[7];
`ifdef PATTERN_010_TX_PARITY_EN
            S_PAR:  x_d = parity_d;
`endif
            S_STOP: x_d = 1'b1;
            default: x_d = 1'b1;
        endcase
    end

    always_comb begin
        fc_d = fc_q;
        if ((state_d == S_STOP) && (state_q != S_STOP) && (fc_q != c_FC_MAX)) begin
            fc_d = fc_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            x_q       <= 1'b1;
            fc_q      <= 10'd0;
`ifdef PATTERN_010_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            x_q       <= x_d;
            fc_q      <= fc_d;
`ifdef PATTERN_010_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_010_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_010_tx
// Purpose  : Directed self-checking bench for pattern_010_tx. It covers
//            reset, single and back-to-back frames, reset mid-frame,
//            random payloads, optional parity and frame_count saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_010_tx;

`ifdef PATTERN_010_TX_PARITY_EN
    localparam int FLEN = 13;
`else
    localparam int FLEN = 12;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       x;
    logic       busy;
    logic [9:0] frame_count;

    int checks = 0;
    int errors = 0;

    pattern_010_tx dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .x          (x),
        .busy       (busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The caller has just passed the accept edge. This task walks the frame
    // up to and including its STOP cycle, and checks x, busy and ready_out.
    task automatic check_frame(input logic [7:0] d, input string tag);
        logic [FLEN-1:0] e;
`ifdef PATTERN_010_TX_PARITY_EN
        e = {3'b010, d, ^d, 1'b1};
`else
        e = {3'b010, d, 1'b1};
`endif
        for (int i = 0; i < FLEN; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s_x%0d", tag, i), {31'd0, x}, {31'd0, e[FLEN-1-i]});
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_rdy%0d", tag, i), {31'd0, ready_out},
                (i == FLEN-1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        rst      = 1'b1;
        valid_in = 1'b1;
        data_in  = 8'hFF;

        // Reset held for two cycles with valid_in high: no frame may start.
        tick();
        tick();
        chk("rst_x",    {31'd0, x},         32'd1);
        chk("rst_rdy",  {31'd0, ready_out}, 32'd1);
        chk("rst_busy", {31'd0, busy},      32'd0);
        chk("rst_fc",   {22'd0, frame_count}, 32'd0);
        rst      = 1'b0;
        valid_in = 1'b0;
        tick();
        chk("rst_nostart", {31'd0, busy}, 32'd0);

        // Single A5 frame. Without parity: 0,1,0,1,0,1,0,0,1,0,1,1.
        data_in  = 8'hA5;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        data_in  = 8'h00;
        check_frame(8'hA5, "a5");
        chk("a5_fc_stop", {22'd0, frame_count}, 32'd1);
        tick();
        chk("a5_idle", {31'd0, busy}, 32'd0);
        chk("a5_fc",   {22'd0, frame_count}, 32'd1);
        chk("a5_xidle", {31'd0, x}, 32'd1);

        // Back-to-back 00 then FF. data_in changes mid-frame and is ignored.
        do_reset();
        data_in  = 8'h00;
        valid_in = 1'b1;
        tick();
        data_in  = 8'hFF;
        check_frame(8'h00, "b2b0");
        tick();
        valid_in = 1'b0;
        check_frame(8'hFF, "b2b1");
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        chk("b2b_fc",   {22'd0, frame_count}, 32'd2);

        // Reset during the 4th data bit of 3C (sample index 6).
        do_reset();
        data_in  = 8'h3C;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (6) tick();
        chk("mid_bit3", {31'd0, x}, 32'd1);   // 3C = 0011_1100, bit 4 is 1
        rst = 1'b1;
        tick();
        chk("mid_x",    {31'd0, x},           32'd1);
        chk("mid_busy", {31'd0, busy},        32'd0);
        chk("mid_rdy",  {31'd0, ready_out},   32'd1);
        chk("mid_fc",   {22'd0, frame_count}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid_stay_idle", {31'd0, busy}, 32'd0);

`ifdef PATTERN_010_TX_PARITY_EN
        // 07 has three ones, so the even-parity bit is 1.
        data_in  = 8'h07;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (11) tick();
        chk("par_bit", {31'd0, x}, 32'd1);
        tick();
        chk("par_stop_rdy", {31'd0, ready_out}, 32'd1);
        tick();
        chk("par_idle", {31'd0, busy}, 32'd0);
        chk("par_fc",   {22'd0, frame_count}, 32'd1);
        do_reset();
`endif

        // Random payloads, with one idle cycle between frames.
        for (int f = 0; f < 20; f++) begin
            r        = 8'($urandom);
            data_in  = r;
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
            check_frame(r, $sformatf("rnd%0d", f));
            tick();
            chk($sformatf("rnd%0d_fc", f), {22'd0, frame_count}, f + 1);
        end

        // Saturation: 1030 back-to-back frames.
        do_reset();
        data_in  = 8'h55;
        valid_in = 1'b1;
        tick();
        for (int f = 1; f <= 1030; f++) begin
            repeat (FLEN - 1) tick();
            chk($sformatf("sat_fc%0d", f), {22'd0, frame_count},
                (f > 1023) ? 32'd1023 : f);
            if (f == 1030) valid_in = 1'b0;
            tick();
        end
        chk("sat_idle",  {31'd0, busy},        32'd0);
        chk("sat_final", {22'd0, frame_count}, 32'd1023);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
